// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the pipelined RISC-V core.
// Latency: reads are combinational, with same-cycle write bypass; writes commit at posedge.
// Backpressure: none. While busy (clear engine active or rst high), reads return 0 and writes are dropped.
// Optional feature macro: REGFILE_SCOREBOARD_EN adds per-register pending bits (rsv_en/rsv_addr/rd_pending).
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    input  logic                   wr0_en,
    input  logic [AW-1:0]          wr0_addr,
    input  logic [XLEN-1:0]        wr0_data,
    input  logic                   wr1_en,
    input  logic [AW-1:0]          wr1_addr,
    input  logic [XLEN-1:0]        wr1_data,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]      rd_pending,
`endif
    output logic                   busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam bit            HAS_ZERO = (ZERO_REG != 0);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_busy;
    logic            w_clr_we;
    logic            w_wr_ok;
    logic            w_wr0_we;
    logic            w_wr1_we;

    // FSM state register: reset always (re)starts the clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: the sweep leaves CLEAR on the edge that writes the last entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_CLEAR: begin
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // FSM outputs: busy covers both the sweep and any cycle with rst asserted
    always_comb begin
        w_busy   = (r_state == S_CLEAR) || rst;
        w_clr_we = (r_state == S_CLEAR) && !rst;
        w_wr_ok  = !w_busy;
    end

    assign busy = w_busy;

    // Clear index: restarts at 0 on reset, advances once per CLEAR cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // Effective write enables: port 1 wins an address collision, x0 is read-only when hardwired
    always_comb begin
        w_wr1_we = w_wr_ok && wr1_en && !(HAS_ZERO && (wr1_addr == '0));
        w_wr0_we = w_wr_ok && wr0_en && !(HAS_ZERO && (wr0_addr == '0))
                   && !(wr1_en && (wr1_addr == wr0_addr));
    end

    // Storage: clear engine has exclusive access while it runs
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            if (w_wr0_we) begin
                r_mem[wr0_addr] <= wr0_data;
            end
            if (w_wr1_we) begin
                r_mem[wr1_addr] <= wr1_data;
            end
        end
    end

    // Read ports: zero reg, then wr1 bypass, then wr0 bypass, then stored value
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (w_busy) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (HAS_ZERO && (rd_addr[k*AW +: AW] == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (wr1_en && (wr1_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*XLEN +: XLEN] = wr1_data;
            end else if (wr0_en && (wr0_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*XLEN +: XLEN] = wr0_data;
            end else begin
                rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;

    // Pending next value: writes clear, reservation set applied last so it wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (wr0_en) begin
            w_pend_nxt[wr0_addr] = 1'b0;
        end
        if (wr1_en) begin
            w_pend_nxt[wr1_addr] = 1'b0;
        end
        if (rsv_en) begin
            w_pend_nxt[rsv_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    // Pending bits: wiped and frozen while the clear engine owns the file
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Pending lookup: stored bits only, a same-cycle write does not hide a pending bit
    always_comb begin
        rd_pending = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_pending[k] = r_pend[rd_addr[k*AW +: AW]];
        end
    end
`endif

endmodule
